// File: rtl/sys_cmd_master.sv
// Host-side system command initiator: serialises one command into an AA/BB/CC/DD
// frame on the UART TX path, then gathers 0..2 response bytes with a timeout guard.
module sys_cmd_master #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 12
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_OP,
  input  logic [7:0]  CMD_ADDR,
  input  logic [7:0]  CMD_WDATA,
  input  logic [7:0]  CMD_OP_A,
  input  logic [7:0]  CMD_OP_B,
  input  logic [3:0]  CMD_FUN,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_DATA_VALID,
  input  logic        TX_BUSY,
  input  logic [7:0]  RX_P_Data,
  input  logic        RX_P_Data_VALID,
  output logic [15:0] RSP_DATA,
  output logic        RSP_VALID,
  output logic        RSP_TIMEOUT,
  output logic        RSP_STRAY
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [7:0]      addr_q, addr_d, wdata_q, wdata_d, opa_q, opa_d, opb_q, opb_d;
  logic [3:0]      fun_q, fun_d;
  logic [1:0]      idx_q, idx_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            rsp_stray_q, rsp_stray_d;
  logic            cmd_ready_q, cmd_ready_d;

  function automatic logic [7:0] frame_byte(input logic [1:0] op, input logic [1:0] idx,
                                            input logic [7:0] addr, input logic [7:0] wdata,
                                            input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] fun);
    logic [7:0] r;
    r = 8'h00;
    case (op)
      2'd0: r = (idx == 2'd0) ? 8'hAA : (idx == 2'd1) ? addr : wdata;
      2'd1: r = (idx == 2'd0) ? 8'hBB : addr;
      2'd2: r = (idx == 2'd0) ? 8'hCC : (idx == 2'd1) ? a : (idx == 2'd2) ? b : {4'h0, fun};
      default: r = (idx == 2'd0) ? 8'hDD : {4'h0, fun};
    endcase
    return r;
  endfunction

  // Index of the final frame byte (L-1) and number of response bytes (R)
  function automatic logic [1:0] frame_last(input logic [1:0] op);
    case (op)
      2'd0:    return 2'd2;
      2'd1:    return 2'd1;
      2'd2:    return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [1:0] rsp_count(input logic [1:0] op);
    case (op)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    fun_d         = fun_q;
    idx_d         = idx_q;
    to_cnt_d      = to_cnt_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = 1'b0;
    rsp_stray_d   = RX_P_Data_VALID && (state_q != WAIT_RSP);
    case (state_q)
      IDLE: if (CMD_VALID) begin
        op_d       = CMD_OP;
        addr_d     = CMD_ADDR;
        wdata_d    = CMD_WDATA;
        opa_d      = CMD_OP_A;
        opb_d      = CMD_OP_B;
        fun_d      = CMD_FUN;
        idx_d      = 2'd0;
        tx_data_d  = frame_byte(CMD_OP, 2'd0, CMD_ADDR, CMD_WDATA, CMD_OP_A, CMD_OP_B, CMD_FUN);
        tx_valid_d = 1'b1;
        rsp_data_d = 16'h0000;
        state_d    = SEND;
      end
      SEND: if (!TX_BUSY) begin
        if (idx_q == frame_last(op_q)) begin
          tx_valid_d = 1'b0;
          idx_d      = 2'd0;
          to_cnt_d   = '0;
          state_d    = (rsp_count(op_q) == 2'd0) ? DONE : WAIT_RSP;
        end else begin
          idx_d     = idx_q + 2'd1;
          tx_data_d = frame_byte(op_q, idx_q + 2'd1, addr_q, wdata_q, opa_q, opb_q, fun_q);
        end
      end
      WAIT_RSP: begin
        // A byte landing on the limit cycle takes priority over the timeout
        if (RX_P_Data_VALID) begin
          if (idx_q == 2'd0) rsp_data_d[7:0]  = RX_P_Data;
          else               rsp_data_d[15:8] = RX_P_Data;
          to_cnt_d = '0;
          idx_d    = idx_q + 2'd1;
          if (idx_q + 2'd1 == rsp_count(op_q)) state_d = DONE;
        end else if (to_cnt_q == TO_LAST) begin
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == DONE);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q       <= IDLE;
      op_q          <= 2'd0;
      addr_q        <= 8'h00;
      wdata_q       <= 8'h00;
      opa_q         <= 8'h00;
      opb_q         <= 8'h00;
      fun_q         <= 4'h0;
      idx_q         <= 2'd0;
      to_cnt_q      <= '0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      rsp_data_q    <= 16'h0000;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_stray_q   <= 1'b0;
      cmd_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      fun_q         <= fun_d;
      idx_q         <= idx_d;
      to_cnt_q      <= to_cnt_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_stray_q   <= rsp_stray_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign CMD_READY     = cmd_ready_q;
  assign TX_P_DATA     = tx_data_q;
  assign TX_DATA_VALID = tx_valid_q;
  assign RSP_DATA      = rsp_data_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_TIMEOUT   = rsp_timeout_q;
  assign RSP_STRAY     = rsp_stray_q;
endmodule
